// File: rtl/breather_pkg.sv
// Shared types for the breathing-light driver: operating mode and ramp direction.
package breather_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STEADY  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/breath_ramp.sv
// Prescaled triangle ramp: level walks 0..MAX..0 one step per STEP_CYC cycles,
// strobing cycle on the step that brings it back to 0.
module breath_ramp
  import breather_pkg::*;
#(
  parameter int PWM_W    = 8,
  parameter int STEP_CYC = 61035
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  mode_e            mode,
  output logic [PWM_W-1:0] level,
  output dir_e             dir,
  output logic             cycle
);

  localparam int              PS_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYC - 1);
  localparam logic [PWM_W-1:0] MAX    = {PWM_W{1'b1}};

  logic [PS_W-1:0] prescale;
  logic            tick;
  logic            ramping;

  assign tick    = (prescale == PS_LAST);
  assign ramping = (mode == MODE_BREATHE) || (mode == MODE_BLINK);

  // OFF clamps the ramp to its reset state on the very next edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale <= {PS_W{1'b0}};
      level    <= {PWM_W{1'b0}};
      dir      <= DIR_UP;
      cycle    <= 1'b0;
    end else if (mode == MODE_OFF) begin
      prescale <= {PS_W{1'b0}};
      level    <= {PWM_W{1'b0}};
      dir      <= DIR_UP;
      cycle    <= 1'b0;
    end else begin
      prescale <= tick ? {PS_W{1'b0}} : prescale + {{(PS_W-1){1'b0}}, 1'b1};
      cycle    <= 1'b0;
      if (ramping && tick) begin
        case (dir)
          DIR_UP: begin
            level <= level + {{(PWM_W-1){1'b0}}, 1'b1};
            if (level == MAX - {{(PWM_W-1){1'b0}}, 1'b1}) begin
              dir <= DIR_DOWN;
            end
          end
          DIR_DOWN: begin
            level <= level - {{(PWM_W-1){1'b0}}, 1'b1};
            if (level == {{(PWM_W-1){1'b0}}, 1'b1}) begin
              dir   <= DIR_UP;
              cycle <= 1'b1;
            end
          end
          default: dir <= DIR_UP;
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_breather.sv
// Multi-channel breathing-light driver: ramp level -> duty (optional gamma),
// period-latched duty compared against a free-running PWM counter.
module pwm_breather
  import breather_pkg::*;
#(
  parameter int CH       = 3,
  parameter int PWM_W    = 8,
  parameter int STEP_CYC = 61035,
  parameter int GAMMA    = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       mode_i,
  input  logic [CH-1:0]    rgb_i,
  output logic [CH-1:0]    rgb_o,
  output logic [PWM_W-1:0] level_o,
  output logic             cycle_o
);

  localparam logic [PWM_W-1:0] MAX = {PWM_W{1'b1}};

  // Quadratic map keeps the top half of level^2; full scale is pinned to MAX
  function automatic logic [PWM_W-1:0] gamma_map(input logic [PWM_W-1:0] lvl);
    logic [2*PWM_W-1:0] sq;
    sq = {{PWM_W{1'b0}}, lvl} * {{PWM_W{1'b0}}, lvl};
    if (GAMMA == 0)      return lvl;
    else if (lvl == MAX) return MAX;
    else                 return PWM_W'(sq >> PWM_W);
  endfunction

  mode_e            mode_in;
  mode_e            mode_q;
  dir_e             dir;
  logic [PWM_W-1:0] level;
  logic [PWM_W-1:0] duty_next;
  logic [PWM_W-1:0] duty_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic             boundary;
  logic             on;
  logic [CH-1:0]    gated;

  assign mode_in = mode_e'(mode_i);
  assign level_o = level;

  breath_ramp #(
    .PWM_W   (PWM_W),
    .STEP_CYC(STEP_CYC)
  ) u_ramp (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .mode  (mode_in),
    .level (level),
    .dir   (dir),
    .cycle (cycle_o)
  );

  always_comb begin
    duty_next = {PWM_W{1'b0}};
    case (mode_in)
      MODE_OFF:     duty_next = {PWM_W{1'b0}};
      MODE_STEADY:  duty_next = MAX;
      MODE_BREATHE: duty_next = gamma_map(level);
      MODE_BLINK:   duty_next = (dir == DIR_UP) ? MAX : {PWM_W{1'b0}};
      default:      duty_next = {PWM_W{1'b0}};
    endcase
  end

  assign boundary = (pwm_cnt == MAX - {{(PWM_W-1){1'b0}}, 1'b1});

  // Duty only moves at the period boundary, except OFF which kills it at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt <= {PWM_W{1'b0}};
      duty_q  <= {PWM_W{1'b0}};
      mode_q  <= MODE_OFF;
    end else begin
      pwm_cnt <= boundary ? {PWM_W{1'b0}} : pwm_cnt + {{(PWM_W-1){1'b0}}, 1'b1};
      if (mode_in == MODE_OFF) begin
        duty_q <= {PWM_W{1'b0}};
        mode_q <= MODE_OFF;
      end else if (boundary) begin
        duty_q <= duty_next;
        mode_q <= mode_in;
      end
    end
  end

  assign on = (mode_in != MODE_OFF) && (mode_q != MODE_OFF) && (pwm_cnt < duty_q);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign gated[c] = rgb_i[c] & on;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_o <= {CH{1'b0}};
    end else begin
      rgb_o <= gated;
    end
  end

endmodule

// File: doc/pwm_breather.md
# pwm_breather

Parametrised multi-channel breathing-light driver, the successor to the fixed 3-channel breather. A prescaled up/down ramp sets a brightness level; a free-running PWM counter compares against a glitch-free latched duty to gate each colour channel. The block supports selectable modes (off, steady, breathe, blink) and optional quadratic gamma, and emits a breath-cycle strobe for downstream sequencing. It sits between the board clock divider and the RGB LED pins.

## Interface
- `CH`, 3: number of output channels.
- `PWM_W`, 8: level/PWM width; MAX = 2^PWM_W − 1.
- `STEP_CYC`, 61035: clock cycles per ramp step (≥1).
- `GAMMA`, 0: 1 enables quadratic duty mapping.

Ports:
- `clk_i` in 1: single block clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `mode_i` in 2: 0 OFF, 1 STEADY, 2 BREATHE, 3 BLINK.
- `rgb_i` in CH: per-channel enable/colour mask.
- `rgb_o` out CH: gated PWM outputs.
- `level_o` out PWM_W: current ramp level.
- `cycle_o` out 1: one-cycle strobe at the end of each full breath.

## Operation
- Reset values: `rgb_o`=0, `level_o`=0, `cycle_o`=0. Internal state: dir=UP, prescaler=0, pwm_cnt=0, duty_q=0, mode_q=OFF.
- Prescaler counts 0..STEP_CYC−1 and wraps. A step tick fires on the cycle it equals STEP_CYC−1.
- Ramp, on a step tick in BREATHE or BLINK:
  - UP: level+1; on reaching MAX, dir←DOWN.
  - DOWN: level−1; on reaching 0, dir←UP and `cycle_o`=1 in the same cycle `level_o` first reads 0.
  - Full breath = 2·MAX ticks = 2·MAX·STEP_CYC cycles.
- OFF: level, dir, prescaler and `cycle_o` are synchronously held at reset values immediately, with no wait for a PWM boundary.
- STEADY: ramp frozen at its current value. No `cycle_o`.
- Duty source:
  - OFF → 0.
  - STEADY → MAX.
  - BREATHE → f(level).
  - BLINK → MAX while dir=UP, 0 while dir=DOWN.
- Gamma mapping f:
  - GAMMA=0: f = level.
  - GAMMA=1: f = (level·level)[2·PWM_W−1:PWM_W], with level=MAX forced to MAX. Multiply width is 2·PWM_W, unsigned, no rounding.
- pwm_cnt counts 0..MAX−1 and wraps, so the period is MAX cycles. duty_q and mode_q are latched only on the cycle pwm_cnt=MAX−1, so duty never changes mid-period. Exception: entering OFF forces duty_q=0 immediately.
- on = (pwm_cnt < duty_q). duty 0 gives always low; duty MAX gives always high; duty d gives exactly d high cycles per period.
- `rgb_o[c]` ← `rgb_i[c]` & on, registered.
- Simultaneous step tick and PWM boundary: the ramp updates first. duty_q latches the value based on the pre-update level; the new level is used at the next boundary.

## Timing
- `rgb_o` lags pwm_cnt/duty_q by 1 cycle. `rgb_i` to `rgb_o` latency is 1 cycle.
- A `mode_i` change (other than to OFF) takes effect at the first PWM boundary after it is sampled. Worst case: MAX+1 cycles to `rgb_o`.
- `level_o` updates on the clock edge of the step tick, with 0 latency.
- `cycle_o` is high for exactly one cycle per breath and is never asserted outside BREATHE/BLINK.
- `rst_ni` asserted mid-operation clears all state asynchronously. After deassertion, the first step tick arrives after STEP_CYC cycles.

## Structure
- Shared package `breather_pkg`: `mode_e` enum (OFF/STEADY/BREATHE/BLINK) and the ramp `dir_e` enum (UP/DOWN).
- Sub-module `breath_ramp`: prescaler, level, dir and `cycle_o` generation. It is parametrised by PWM_W and STEP_CYC.
- The top level holds the gamma map, duty/mode latch, PWM counter and per-channel gating (a generate loop over CH).

## Test plan
For all tests: CH=3, PWM_W=4 (MAX=15), STEP_CYC=2, GAMMA=0 unless stated.
- Reset: hold `rst_ni`=0 with `mode_i`=BREATHE and `rgb_i`=3'b111, release → `rgb_o`=0 and `level_o`=0; `level_o`=1 after 2 cycles; `cycle_o` first pulses after 60 cycles.
- BREATHE ramp: `level_o` sequence 0,1..15,14..0 with 2 cycles per step; `cycle_o` is a single pulse coincident with the return to 0; in a period latched at duty 5, each channel is high exactly 5 of 15 cycles.
- STEADY with `rgb_i`=3'b101: after one PWM boundary, `rgb_o`=3'b101 constantly; `level_o` frozen; no `cycle_o`.
- BLINK: `rgb_o` fully high for all 15 periods' worth while dir=UP, fully low while DOWN; switch to OFF mid-period → `rgb_o`=0 within 1 cycle and `level_o`=0.
- GAMMA=1: level 8 gives duty 4; level 15 gives duty 15; level 3 gives duty 0 (zero high cycles).
- Async reset mid-breath (`level_o`=9, DOWN) → all outputs 0 immediately; after release, the ramp restarts UP from 0.
